// File: rtl/sync_frame_pkg.sv
// -----------------------------------------------------------------------------
// sync_frame_pkg
// Shared types and helpers for the serial frame transmitter.
//   tx_state_t  : transmitter FSM state encoding
//   SYNC_1101   : default sync pattern (sent MSB first)
//   cnt_width() : bit counter width, wide enough for the longest state
// -----------------------------------------------------------------------------
package sync_frame_pkg;

    // ST_PARITY is only reachable when SYNC_FRAME_TX_PARITY_EN is defined;
    // the encoding is kept fixed so debug views match across builds.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } tx_state_t;

    localparam logic [3:0] SYNC_1101 = 4'b1101;

    // $clog2(max(sync_w, data_w, gap_cycles) + 1)
    function automatic int cnt_width(input int sync_w, input int data_w,
                                     input int gap_cycles);
        int m;
        m = sync_w;
        if (data_w > m)     m = data_w;
        if (gap_cycles > m) m = gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// -----------------------------------------------------------------------------
// piso_shift
// Parallel-load, MSB-first shift register.
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset (clears the register)
//   i_load     in   load i_data (takes priority over i_shift)
//   i_shift    in   shift left by one, zero fill
//   i_data     in   DATA_W parallel word
//   o_msb      out  current MSB (bit on the line this cycle)
//   o_next_msb out  bit that becomes the MSB after the next shift
// -----------------------------------------------------------------------------
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb,
    output logic              o_next_msb
);

    logic [DATA_W-1:0] r_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= r_sh << 1;
        end
    end

    assign o_msb = r_sh[DATA_W-1];

    // A one-bit register has nothing behind its MSB; zero fill applies.
    generate
        if (DATA_W > 1) begin : g_next_wide
            assign o_next_msb = r_sh[DATA_W-2];
        end else begin : g_next_one
            assign o_next_msb = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sync_frame_tx.sv
// -----------------------------------------------------------------------------
// sync_frame_tx
// Serial frame transmitter for the single-wire test link. Each accepted word
// is sent as: sync pattern (MSB first), payload (MSB first), optional even
// parity bit, then GAP_CYCLES idle-low cycles.
//
// Build option: define SYNC_FRAME_TX_PARITY_EN to append an even-parity bit
// (XOR of the payload) after the payload.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-high reset
//   data_in      in   DATA_W payload, sampled only on an accept
//   data_valid   in   payload offered
//   data_ready   out  can accept (combinational, high only in IDLE)
//   tx_out       out  serial line (registered)
//   tx_active    out  high while sync/data/parity bits are on tx_out (registered)
//   frame_done   out  one-cycle pulse in the first GAP cycle (registered)
//   o_dbg_state  out  current FSM state
//
// Handshake: a word is transferred on a rising edge where data_valid and
// data_ready are both high. data_ready does not depend on data_valid; data_valid
// seen while data_ready is low is ignored, so no word is dropped or repeated.
// -----------------------------------------------------------------------------
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int               DATA_W       = 8,
    parameter int               SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_1101,
    parameter int               GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              tx_active,
    output logic              frame_done,
    output tx_state_t         o_dbg_state
);

    localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_tx_out;
    logic             r_tx_active;
    logic             r_frame_done;
    logic             w_tx_nxt;
    logic             w_active_nxt;
    logic             w_done_nxt;
    logic             w_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_shift;
    logic             w_msb;
    logic             w_next_msb;
    logic             w_sync_bit;

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic             r_parity;
`endif

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = data_valid && w_ready;

    // -------------------------------------------------------------------------
    // Payload shift register
    // -------------------------------------------------------------------------
    piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (data_in),
        .o_msb      (w_msb),
        .o_next_msb (w_next_msb)
    );

    // -------------------------------------------------------------------------
    // FSM: state and bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = SYNC_LAST;
                    w_load      = 1'b1;
                end
            end
            ST_SYNC: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = DATA_LAST;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                // The shift on the last data cycle is harmless: the register
                // is reloaded before it is read again.
                w_shift = 1'b1;
                if (r_cnt == CNT_ZERO) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = GAP_LAST;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = GAP_LAST;
            end
`endif
            ST_GAP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                // Unreachable encodings recover to IDLE.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered line outputs. Each output register is loaded with the value
    // belonging to the state being entered, so tx_out/tx_active/frame_done
    // line up cycle-for-cycle with r_state.
    // -------------------------------------------------------------------------

    // SYNC_PATTERN[w_cnt_nxt] written as a compare loop so the counter width
    // need not match the pattern index width.
    always_comb begin
        w_sync_bit = 1'b0;
        for (int i = 0; i < SYNC_W; i++) begin
            if (w_cnt_nxt == CNT_W'(i)) begin
                w_sync_bit = SYNC_PATTERN[i];
            end
        end
    end

    always_comb begin
        w_tx_nxt     = 1'b0;
        w_active_nxt = 1'b0;
        case (w_state_nxt)
            ST_SYNC: begin
                w_tx_nxt     = w_sync_bit;
                w_active_nxt = 1'b1;
            end
            ST_DATA: begin
                // Entering DATA the register holds the untouched word; while
                // in DATA it shifts on this edge, so the following bit is next.
                w_tx_nxt     = (r_state == ST_DATA) ? w_next_msb : w_msb;
                w_active_nxt = 1'b1;
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                w_tx_nxt     = r_parity;
                w_active_nxt = 1'b1;
            end
`endif
            default: begin
                w_tx_nxt     = 1'b0;
                w_active_nxt = 1'b0;
            end
        endcase
        w_done_nxt = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_out     <= 1'b0;
            r_tx_active  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_out     <= w_tx_nxt;
            r_tx_active  <= w_active_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

`ifdef SYNC_FRAME_TX_PARITY_EN
    // Parity is taken from the word as accepted, since the shift register is
    // consumed while the payload goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^data_in;
        end
    end
`endif

    assign data_ready  = w_ready;
    assign tx_out      = r_tx_out;
    assign tx_active   = r_tx_active;
    assign frame_done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sync_frame_tx.sv
module tb_sync_frame_tx;
    import sync_frame_pkg::*;

    localparam int GAP = 2;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int L = 13;
`else
    localparam int L = 12;
`endif
    localparam int P = L + GAP + 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx_out;
    logic       tx_active;
    logic       frame_done;
    tx_state_t  dbg_state;

    always #5 clk = ~clk;

    sync_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .tx_out      (tx_out),
        .tx_active   (tx_active),
        .frame_done  (frame_done),
        .o_dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic cap_tx   [0:63];
    logic cap_act  [0:63];
    logic cap_done [0:63];
    logic cap_rdy  [0:63];

    // Expected on-line bits of one frame, right aligned, first bit at [L-1].
    function automatic logic [12:0] frame_bits(input logic [7:0] d);
`ifdef SYNC_FRAME_TX_PARITY_EN
        return {4'b1101, d, ^d};
`else
        return {1'b0, 4'b1101, d};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Driver: sample n cycles (index k = k+1 cycles after the first edge),
    // dropping data_valid after sample drop_at, optionally scrambling data_in.
    // ------------------------------------------------------------------
    task automatic capture(input int n, input int drop_at, input bit scramble);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cap_tx[k]   = tx_out;
            cap_act[k]  = tx_active;
            cap_done[k] = frame_done;
            cap_rdy[k]  = data_ready;
            if (k == drop_at) data_valid = 1'b0;
            if (scramble) data_in = 8'($urandom_range(0, 255));
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL reset_tx_out: got %b want 0", tx_out); end
        n_cmp++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL reset_tx_active: got %b want 0", tx_active); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", data_ready); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_idle();
        data_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL idle_tx_out[%0d]: got %b want 0", k, tx_out); end
            n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL idle_frame_done[%0d]: got %b want 0", k, frame_done); end
        end
    endtask

    // One frame with a single-cycle valid; window covers frame, gap and one idle.
    task automatic test_single_frame(input logic [7:0] d, input bit scramble);
        logic [12:0] exp_bits;
        logic [12:0] obs_bits;
        logic [31:0] obs_act, obs_done, obs_rdy, obs_gap;
        logic [31:0] exp_act, exp_done, exp_rdy;
        exp_bits = frame_bits(d);
        data_in    = d;
        data_valid = 1'b1;
        capture(P, 0, scramble);
        obs_bits = '0; obs_act = '0; obs_done = '0; obs_rdy = '0; obs_gap = '0;
        for (int k = 0; k < L; k++) obs_bits[L-1-k] = cap_tx[k];
        for (int k = 0; k < P; k++) begin
            obs_act[k]  = cap_act[k];
            obs_done[k] = cap_done[k];
            obs_rdy[k]  = cap_rdy[k];
            if (k >= L) obs_gap[k] = cap_tx[k];
        end
        exp_act  = (32'd1 << L) - 32'd1;
        exp_done = 32'd1 << L;
        exp_rdy  = 32'd1 << (L + GAP);
        n_cmp++; if (obs_bits !== exp_bits) begin n_err++; $display("FAIL frame_bits d=%h: got %b want %b", d, obs_bits, exp_bits); end
        n_cmp++; if (obs_gap !== 32'd0) begin n_err++; $display("FAIL gap_low d=%h: got %b want 0", d, obs_gap); end
        n_cmp++; if (obs_act !== exp_act) begin n_err++; $display("FAIL tx_active d=%h: got %b want %b", d, obs_act, exp_act); end
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL frame_done d=%h: got %b want %b", d, obs_done, exp_done); end
        n_cmp++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL data_ready d=%h: got %b want %b", d, obs_rdy, exp_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp1, exp2, obs1, obs2;
        logic [63:0] obs_act, obs_done, obs_zero;
        logic [63:0] exp_act, exp_done;
        int n;
        n = 2 * P + 2;
        exp1 = frame_bits(8'h0F);
        exp2 = frame_bits(8'hF0);
        data_in    = 8'h0F;
        data_valid = 1'b1;
        // First edge accepts 0x0F; present 0xF0 for the next accept, keep valid
        // held through it and drop it once the second frame is running.
        @(posedge clk);
        #1;
        cap_tx[0] = tx_out; cap_act[0] = tx_active; cap_done[0] = frame_done; cap_rdy[0] = data_ready;
        data_in = 8'hF0;
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            #1;
            cap_tx[k]   = tx_out;
            cap_act[k]  = tx_active;
            cap_done[k] = frame_done;
            cap_rdy[k]  = data_ready;
            if (k == P + 1) data_valid = 1'b0;
        end
        obs1 = '0; obs2 = '0; obs_act = '0; obs_done = '0; obs_zero = '0;
        for (int k = 0; k < L; k++) begin
            obs1[L-1-k] = cap_tx[k];
            obs2[L-1-k] = cap_tx[P+k];
        end
        for (int k = 0; k < n; k++) begin
            obs_act[k]  = cap_act[k];
            obs_done[k] = cap_done[k];
            if ((k >= L && k < P) || k >= P + L) obs_zero[k] = cap_tx[k];
        end
        exp_act  = ((64'd1 << L) - 64'd1) | (((64'd1 << L) - 64'd1) << P);
        exp_done = (64'd1 << L) | (64'd1 << (P + L));
        n_cmp++; if (obs1 !== exp1) begin n_err++; $display("FAIL b2b_frame1: got %b want %b", obs1, exp1); end
        n_cmp++; if (obs2 !== exp2) begin n_err++; $display("FAIL b2b_frame2: got %b want %b", obs2, exp2); end
        n_cmp++; if (obs_act !== exp_act) begin n_err++; $display("FAIL b2b_tx_active: got %h want %h", obs_act, exp_act); end
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL b2b_frame_done: got %h want %h", obs_done, exp_done); end
        n_cmp++; if (obs_zero !== 64'd0) begin n_err++; $display("FAIL b2b_line_low: got %h want 0", obs_zero); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] obs_act, obs_done;
        data_in    = 8'hA5;
        data_valid = 1'b1;
        // Indices 0..3 are sync, 4..6 the first three data bits (1,0,1).
        capture(7, 0, 1'b0);
        n_cmp++; if (tx_out !== 1'b1) begin n_err++; $display("FAIL mid_pre_tx_out: got %b want 1", tx_out); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (tx_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_out: got %b want 0", tx_out); end
        n_cmp++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_active: got %b want 0", tx_active); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_frame_done: got %b want 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b want 1", data_ready); end
        capture(8, -1, 1'b0);
        obs_act = '0; obs_done = '0;
        for (int k = 0; k < 8; k++) begin
            obs_act[k]  = cap_act[k];
            obs_done[k] = cap_done[k];
        end
        n_cmp++; if (obs_act !== 8'd0) begin n_err++; $display("FAIL mid_after_active: got %b want 0", obs_act); end
        n_cmp++; if (obs_done !== 8'd0) begin n_err++; $display("FAIL mid_no_done: got %b want 0", obs_done); end
        test_single_frame(8'h5A, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_idle();
        test_single_frame(8'hA5, 1'b0);
        test_back_to_back();
        test_reset_mid_frame();
        test_single_frame(8'h3C, 1'b1);
        test_single_frame(8'h81, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

Serial frame transmitter that produces the bit stream our serial sequence detectors consume. On each accepted parallel word it emits a fixed sync pattern (default 1101), MSB first, then the payload MSB first, optionally followed by an even-parity bit. It then holds the line low for a programmable gap. It sits on the transmit side of the single-wire test link and drives the `in` input of the downstream detector.

## Interface
- `DATA_W`, default 8: payload width in bits, ≥1.
- `SYNC_W`, default 4: sync pattern width in bits, ≥1.
- `SYNC_PATTERN`, default 4'b1101: sync bits, sent MSB first.
- `GAP_CYCLES`, default 2: idle-low cycles after each frame, ≥1.
- Reset is `rst`: asynchronous, active-high. Clock is `clk`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_W  payload word, sampled only on an accept.
- `data_valid`  in  1  payload offered.
- `data_ready`  out  1  block can accept; combinational, high only in IDLE.
- `tx_out`  out  1  serial line, registered.
- `tx_active`  out  1  high while a sync, data or parity bit is on `tx_out`; registered.
- `frame_done`  out  1  single-cycle pulse in the first GAP cycle after a frame.

## Operation
- States: IDLE, SYNC, DATA, PARITY (present only with the macro), GAP.
- IDLE: `tx_out`=0, `tx_active`=0, `data_ready`=1.
- Accept: `data_valid` && `data_ready` at a rising edge.
  - `data_in` is latched into the shift register.
  - Bit counter loads SYNC_W-1.
  - Next state is SYNC.
- SYNC: `tx_out` = SYNC_PATTERN[counter], counting down to 0, then DATA with the counter at DATA_W-1.
- DATA: `tx_out` = latched[DATA_W-1], shifting left each cycle. After DATA_W bits the next state is PARITY if enabled, otherwise GAP.
- PARITY: one cycle; `tx_out` = XOR of all latched payload bits (even parity).
- GAP: `tx_out`=0 for GAP_CYCLES cycles. `frame_done`=1 in the first GAP cycle only. Then IDLE.
- `data_valid` low in IDLE: stay in IDLE and the line stays 0.
- `data_valid` high outside IDLE: ignored. `data_ready` is 0 there, so no word is lost or duplicated.
- Changing `data_in` after an accept has no effect on the frame in flight.
- Counter width: $clog2(max(SYNC_W, DATA_W, GAP_CYCLES)+1). No wrap occurs within a state.
- Reset at any time, including mid-frame: asynchronous return to IDLE with `tx_out`=0, `tx_active`=0 and `frame_done`=0. The aborted frame gets no `frame_done`.
- Illegal state encoding: go to IDLE.

## Timing
- Reset values:
  - `tx_out`=0, `tx_active`=0, `frame_done`=0.
  - `data_ready`=1 once `rst` is low.
- Latency: first sync bit appears on `tx_out` in the cycle after the accepting edge.
- Frame length L = SYNC_W + DATA_W (+1 with parity). `tx_active` is high for exactly L consecutive cycles.
- Accept-to-accept minimum period: L + GAP_CYCLES + 1 cycles. With `data_valid` held high, the next accept happens on the edge that ends the first IDLE cycle.
- `frame_done` is asserted in cycle L+1 after the accept edge.

## Configuration
- Macro `SYNC_FRAME_TX_PARITY_EN`.
- Defined: PARITY state is compiled in and frames carry a trailing even-parity bit.
- Undefined: no PARITY state; DATA goes directly to GAP and frame length is SYNC_W + DATA_W.

## Structure
- Package `sync_frame_pkg` holds:
  - the state enum `tx_state_t`;
  - the default sync constant `SYNC_1101` = 4'b1101;
  - a localparam function for the counter width.
- Sub-module `piso_shift`: parallel-load, MSB-first shift register of width DATA_W with load/shift enables and async reset. The FSM, counter and parity XOR stay in the top.

## Test plan
- Reset, then `data_in`=0xA5 with one-cycle valid → `tx_out` = 1101 10100101, no parity bit. `tx_active` is high 12 cycles, then 0 for 2 cycles; `frame_done` pulses once.
- Same stimulus with `SYNC_FRAME_TX_PARITY_EN` → 1101 10100101 0 (0xA5 has four ones); `tx_active` is high 13 cycles.
- `data_valid` held high with 0x0F then 0xF0 → two frames separated by exactly 2 zero cycles plus 1 IDLE cycle. Each word is sent once.
- `rst` pulsed in the 3rd DATA cycle → `tx_out`, `tx_active` and `frame_done` are 0 asynchronously; `data_ready`=1 after release; the next frame is sent cleanly.
- `data_in` toggled every cycle during a frame for latched 0x3C → payload on the line is exactly 00111100.
- `data_valid`=0 for 20 cycles after reset → `tx_out`=0 and `frame_done`=0 throughout.
